// File: rtl/fsic_clock_div_prog.sv
// Programmable multi-channel clock divider: each channel divides in_i by a
// clamped ratio, with a look-ahead rise strobe and a ratio-change strobe.
//
// state | meaning
// IDLE  | cnt=0, out held high, ratio tracked; leaves on en
// RUN   | cnt counts 0..N-1; ratio and en re-sampled only at the wrap
module fsic_clock_div_prog #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 4,
  parameter int DEF_RATIO = 4
) (
  input  logic                    in_i,
  input  logic                    resetb_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       out_o,
  output logic [NUM_CH-1:0]       rise_pre_o,
  output logic [NUM_CH-1:0]       div_upd_o
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [DIV_W-1:0] RATIO_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] RATIO_RST = DIV_W'(DEF_RATIO);

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [DIV_W-1:0]  n_q     [NUM_CH];
  logic [DIV_W-1:0]  n_d     [NUM_CH];
  logic [DIV_W-1:0]  req_n   [NUM_CH];
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] upd_q, upd_d;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      req_n[k] = div_ratio_i[k*DIV_W +: DIV_W];
      if (req_n[k] < RATIO_MIN) req_n[k] = RATIO_MIN;
    end
  end

  always_comb begin
    out_d  = '0;
    rise_d = '0;
    upd_d  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      n_d[k]     = n_q[k];
      if (sync_i) begin
        cnt_d[k]   = '0;
        n_d[k]     = req_n[k];
        state_d[k] = en_i[k] ? RUN : IDLE;
      end else if (state_q[k] == IDLE) begin
        // The idle cycle itself stands in for cnt=0 of the first period.
        n_d[k]     = req_n[k];
        cnt_d[k]   = en_i[k] ? DIV_W'(1) : '0;
        state_d[k] = en_i[k] ? RUN : IDLE;
      end else if (cnt_q[k] == n_q[k] - DIV_W'(1)) begin
        cnt_d[k]   = '0;
        n_d[k]     = req_n[k];
        state_d[k] = en_i[k] ? RUN : IDLE;
      end else begin
        cnt_d[k]   = cnt_q[k] + DIV_W'(1);
      end
      upd_d[k]  = (n_d[k] != n_q[k]);
      out_d[k]  = ({1'b0, cnt_d[k]} < (({1'b0, n_d[k]} + (DIV_W+1)'(1)) >> 1));
      rise_d[k] = (state_d[k] == RUN) && (cnt_d[k] == n_d[k] - DIV_W'(1));
    end
  end

  always_ff @(posedge in_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
        n_q[k]     <= RATIO_RST;
      end
      out_q  <= '1;
      rise_q <= '0;
      upd_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        n_q[k]     <= n_d[k];
      end
      out_q  <= out_d;
      rise_q <= rise_d;
      upd_q  <= upd_d;
    end
  end

  assign out_o      = out_q;
  assign rise_pre_o = rise_q;
  assign div_upd_o  = upd_q;

endmodule

// File: tb/tb_fsic_clock_div_prog.sv
// Bench for fsic_clock_div_prog: directed literal sequences plus a random run
// checked every cycle against a period-list model of each channel.
module tb_fsic_clock_div_prog;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 4;
  localparam int DEF    = 4;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [1:0] en = 2'b00;
  logic [7:0] ratio = 8'h44;
  logic       sync = 1'b0;
  logic [1:0] out, rise, upd;

  int checks = 0;
  int errors = 0;
  bit mvalid = 1'b0;

  fsic_clock_div_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_RATIO(DEF)) dut (
    .in_i(clk), .resetb_i(resetb), .en_i(en), .div_ratio_i(ratio),
    .sync_i(sync), .out_o(out), .rise_pre_o(rise), .div_upd_o(upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel holds the list of {upd,rise,out} values still to come
  // in its current period; a new list is generated when the period runs out.
  int         mode [2];
  int         mn   [2];
  logic [2:0] mq   [2][$];

  function automatic int clampr(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  task automatic begin_period(input int k, input int r, input int first, input bit e);
    bit chg;
    chg = (r != mn[k]);
    mn[k] = r;
    mq[k].delete();
    if (e) begin
      for (int i = first; i < r; i++)
        mq[k].push_back({(i == first) && chg, i == r - 1, i < (r + 1) / 2});
      mode[k] = 1;
    end else begin
      mq[k].push_back({chg, 1'b0, 1'b1});
      mode[k] = 0;
    end
  endtask

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < 2; k++) begin
        mode[k] = 0;
        mn[k] = DEF;
        mq[k].delete();
        mq[k].push_back(3'b001);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int r;
        r = clampr(int'(ratio[k*4 +: 4]));
        if (sync) begin_period(k, r, 0, en[k]);
        else if (mode[k] == 0) begin_period(k, r, 1, en[k]);
        else begin
          void'(mq[k].pop_front());
          if (mq[k].size() == 0) begin_period(k, r, 0, en[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        if (mq[k].size() == 0) begin
          chk($sformatf("model_empty%0d", k), 32'd0, 32'd1);
        end else begin
          chk($sformatf("out%0d", k), out[k], mq[k][0][0]);
          chk($sformatf("rise_pre%0d", k), rise[k], mq[k][0][1]);
          chk($sformatf("div_upd%0d", k), upd[k], mq[k][0][2]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] e, input logic [7:0] r);
    resetb = 1'b0;
    en = e;
    ratio = r;
    sync = 1'b0;
    step();
    step();
    resetb = 1'b1;
  endtask

  initial begin
    int o1[8], r1[8], o3[9], u3[9], o4a[7], o4b[5], o6[4];
    o1 = '{1,1,0,0,1,1,0,0};
    r1 = '{0,0,0,1,0,0,0,1};
    o3 = '{1,0,0,1,1,1,0,0,0};
    u3 = '{0,0,0,1,0,0,0,0,0};
    o4a = '{1,0,0,1,1,1,1};
    o4b = '{1,1,0,0,1};
    o6 = '{1,1,0,0};

    step();
    mvalid = 1'b1;

    // ratio 4 on both channels from reset
    do_reset(2'b11, 8'h44);
    for (int i = 0; i < 8; i++) begin
      chk("t1_out0", out[0], o1[i]);
      chk("t1_out1", out[1], o1[i]);
      chk("t1_rise0", rise[0], r1[i]);
      step();
    end

    // independent ratios 5 and 2
    do_reset(2'b11, 8'h25);
    for (int i = 0; i < 10; i++) begin
      chk("t2_out0", out[0], (i % 5) < 3);
      chk("t2_out1", out[1], (i % 2) == 0);
      step();
    end

    // ratio change 4->6 at cnt=1 waits for the wrap
    do_reset(2'b11, 8'h44);
    step();
    ratio = 8'h46;
    for (int i = 0; i < 9; i++) begin
      chk("t3_out0", out[0], o3[i]);
      chk("t3_upd0", upd[0], u3[i]);
      step();
    end

    // en0 dropped mid-period, then re-raised
    do_reset(2'b11, 8'h44);
    step();
    en = 2'b10;
    for (int i = 0; i < 7; i++) begin
      chk("t4_out0_stop", out[0], o4a[i]);
      step();
    end
    en = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("t4_out0_resume", out[0], o4b[i]);
      step();
    end

    // sync with channels at different phases, ratios 0 and 1 clamp to 2
    do_reset(2'b11, 8'h35);
    step();
    step();
    chk("t5_phase_diff", out, 2'b01);
    sync = 1'b1;
    ratio = 8'h10;
    step();
    sync = 1'b0;
    chk("t5_sync_out", out, 2'b11);
    chk("t5_sync_upd", upd, 2'b11);
    for (int i = 0; i < 4; i++) begin
      chk("t5_out0", out[0], (i % 2) == 0);
      chk("t5_out1", out[1], (i % 2) == 0);
      step();
    end

    // reset asserted during the low phase
    do_reset(2'b11, 8'h44);
    step();
    step();
    chk("t6_low_phase", out[0], 1'b0);
    resetb = 1'b0;
    #1;
    chk("t6_async_out", out, 2'b11);
    chk("t6_async_rise", rise, 2'b00);
    step();
    resetb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_out0", out[0], o6[i]);
      step();
    end

    // random traffic checked by the model
    en = 2'b11;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) ratio[3:0] = 4'($urandom);
      if ($urandom_range(0, 5) == 0) ratio[7:4] = 4'($urandom);
      if ($urandom_range(0, 15) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 15) == 0) en[1] = ~en[1];
      sync = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 299) == 0) begin
        resetb = 1'b0;
        step();
        resetb = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsic_clock_div_prog.md
FSIC_CLOCK_DIV_PROG -- requirements
Module: fsic_clock_div_prog

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divided-clock channels.
REQ-002 Parameter DIV_W, default 4: width of each channel's divide-ratio field.
REQ-003 Parameter DEF_RATIO, default 4: per-channel active ratio loaded at reset; legal range 2..2^DIV_W-1.
REQ-004 in  input  1: source clock; one clock, all logic on its rising edge.
REQ-005 resetb  input  1: reset, asynchronous and active-low.
REQ-006 en  input  NUM_CH: per-channel run enable.
REQ-007 div_ratio  input  NUM_CH*DIV_W: requested ratio per channel; channel k uses bits [k*DIV_W +: DIV_W].
REQ-008 sync  input  1: synchronous phase-align strobe for all channels.
REQ-009 out  output  NUM_CH: divided clocks, registered.
REQ-010 rise_pre  output  NUM_CH: one-cycle strobe, high in the in-cycle before out[k] rises.
REQ-011 div_upd  output  NUM_CH: one-cycle strobe, high when a changed ratio takes effect.

Function
REQ-012 Each channel SHALL hold a counter cnt (DIV_W bits), an active ratio N, and a registered out; channels SHALL NOT interact except through sync.
REQ-013 Effective ratio SHALL be max(div_ratio field, 2); values 0 and 1 SHALL be treated as 2.
REQ-014 Running channel: cnt SHALL count 0..N-1 and wrap to 0; out SHALL be 1 while cnt < ceil(N/2), else 0; period SHALL be exactly N in-cycles.
REQ-015 out SHALL be driven from a flop (no combinational path from inputs); it changes only on rising edges of in.
REQ-016 The ratio SHALL be sampled only at a wrap (cnt==N-1 going to 0); the new N governs the period beginning at that wrap; mid-period changes of div_ratio SHALL have no effect until the next wrap.
REQ-017 div_upd[k] SHALL be 1 for exactly the first cycle of a period whose N differs from the previous N; otherwise 0.
REQ-018 rise_pre[k] SHALL be 1 exactly when the channel is running and cnt==N-1; otherwise 0.
REQ-019 States per channel: IDLE (cnt=0, out=1, hold) and RUN.
REQ-020 IDLE -> RUN on a rising edge with en[k]=1; the first RUN cycle SHALL be cnt=1, so the high phase counts the IDLE cycle as cnt=0.
REQ-021 RUN -> IDLE only at a wrap with en[k]=0; deasserting en mid-period SHALL complete the current period, with no truncated pulse.
REQ-022 sync=1 on an edge SHALL force every channel to cnt=0, out=1, load N from div_ratio (clamped), and enter RUN if en[k]=1, else IDLE.
REQ-023 sync SHALL take priority over en and wrap logic.
REQ-024 During sync, rise_pre=0; div_upd SHALL follow REQ-017 against the previous N.
REQ-025 With N=2 the output SHALL toggle every cycle; with odd N the duty SHALL be high ceil(N/2), low floor(N/2).

Reset
REQ-026 resetb=0 SHALL asynchronously force every channel to IDLE, with cnt=0, N=DEF_RATIO, out=1, rise_pre=0, div_upd=0.
REQ-027 Release of resetb SHALL be sampled on the first rising edge of in; behaviour then follows REQ-020.
REQ-028 Assertion of resetb mid-period SHALL immediately drive out=1 regardless of phase.

Verification
REQ-029 Reset, en=all 1, div_ratio=4 per channel -> out[k] repeats 1,1,0,0 from the first cycle; rise_pre high on every 4th cycle (cnt=3).
REQ-030 ch0 ratio 5 -> out0 = 1,1,1,0,0 repeating; ch1 ratio 2 -> out1 = 1,0 repeating; the two channels are independent.
REQ-031 ch0 running N=4; div_ratio changed to 6 at cnt=1 -> current period stays 4 cycles; next period is 6 cycles (3 high, 3 low); div_upd pulses once on its first cycle.
REQ-032 en0 dropped at cnt=1 of N=4 -> out0 completes 1,1,0,0 then holds 1 in IDLE; en0 re-raised -> pattern resumes 1,1,0,0 with no glitch.
REQ-033 Channels at different phases, sync pulsed one cycle -> all out=1 and cnt=0 on the next edge; ratio 0 or 1 is clamped to 2 after sync.
REQ-034 resetb pulsed low mid low-phase -> out=1 immediately; after release, N=DEF_RATIO and pattern restarts at cnt=0.
